// File: rtl/julia_work_dispatcher.sv
// julia_work_dispatcher: walks every pixel of a frame and hands each one to a
// free Julia worker using round-robin selection, tracking per-worker busy
// state, with frame start / abort / drain control and a frame-complete pulse.
module julia_work_dispatcher #(
  parameter int NUM_WORKERS = 16,
  parameter int NUM_X_BITS  = 10,
  parameter int NUM_Y_BITS  = 10,
  parameter int X_MAX       = 640,
  parameter int Y_MAX       = 480,
  parameter int C_BITS      = 22,
  parameter int ID_BITS     = $clog2(NUM_WORKERS)
) (
  input  logic                     clk,
  input  logic                     n_rst,
  input  logic                     start_frame,
  input  logic                     abort,
  input  logic signed [C_BITS-1:0] a_in,
  input  logic signed [C_BITS-1:0] b_in,
  input  logic [NUM_WORKERS-1:0]   worker_done,
  output logic [NUM_WORKERS-1:0]   worker_start,
  output logic [NUM_X_BITS-1:0]    assign_x,
  output logic [NUM_Y_BITS-1:0]    assign_y,
  output logic signed [C_BITS-1:0] assign_a,
  output logic signed [C_BITS-1:0] assign_b,
  output logic [ID_BITS-1:0]       assign_id,
  output logic                     assign_valid,
  output logic [NUM_WORKERS-1:0]   busy_mask,
  output logic                     frame_busy,
  output logic                     frame_done,
  output logic                     frame_aborted
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DISPATCH,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t                   state_q;
  state_t                   state_d;
  logic [NUM_X_BITS-1:0]    x_q;
  logic [NUM_Y_BITS-1:0]    y_q;
  logic [ID_BITS-1:0]       ptr_q;
  logic                     aborted_q;

  logic                     grant_vld_p0;
  logic [ID_BITS-1:0]       grant_id_p0;
  logic [NUM_WORKERS-1:0]   grant_oh_p0;
  logic                     last_pix;
  logic                     drain_empty;

  assign last_pix    = (x_q == NUM_X_BITS'(X_MAX - 1)) && (y_q == NUM_Y_BITS'(Y_MAX - 1));
  assign drain_empty = (state_q == S_DRAIN) && (busy_mask == '0);
  assign grant_oh_p0 = grant_vld_p0 ? (NUM_WORKERS'(1) << grant_id_p0) : '0;

  // Round-robin pick: the free worker closest after the pointer wins; the
  // loop walks from the farthest candidate to the nearest so the nearest
  // free one is the last (and final) assignment.
  always_comb begin
    logic [ID_BITS-1:0] idx;
    grant_vld_p0 = 1'b0;
    grant_id_p0  = '0;
    idx          = '0;
    if (state_q == S_DISPATCH) begin
      for (int k = NUM_WORKERS; k >= 1; k--) begin
        idx = ID_BITS'((int'(ptr_q) + k) % NUM_WORKERS);
        if (!busy_mask[idx]) begin
          grant_vld_p0 = 1'b1;
          grant_id_p0  = idx;
        end
      end
    end
  end

  // Frame sequencing: abort and the final grant both end dispatch; drain
  // waits for every worker to report back before the one-cycle done state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:     if (start_frame) state_d = S_DISPATCH;
      S_DISPATCH: if (abort || (grant_vld_p0 && last_pix)) state_d = S_DRAIN;
      S_DRAIN:    if (busy_mask == '0) state_d = S_DONE;
      S_DONE:     state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  // Control state: FSM, busy flags, round-robin pointer, abort flag and the
  // frame status outputs.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q       <= S_IDLE;
      busy_mask     <= '0;
      ptr_q         <= ID_BITS'(NUM_WORKERS - 1);
      aborted_q     <= 1'b0;
      frame_busy    <= 1'b0;
      frame_done    <= 1'b0;
      frame_aborted <= 1'b0;
      worker_start  <= '0;
      assign_valid  <= 1'b0;
    end else begin
      state_q       <= state_d;
      busy_mask     <= (busy_mask & ~worker_done) | grant_oh_p0;
      worker_start  <= grant_oh_p0;
      assign_valid  <= grant_vld_p0;
      frame_busy    <= (state_d == S_DISPATCH) || (state_d == S_DRAIN);
      frame_done    <= drain_empty;
      frame_aborted <= drain_empty && aborted_q;
      if (grant_vld_p0) ptr_q <= grant_id_p0;
      if ((state_q == S_IDLE) && start_frame) begin
        aborted_q <= 1'b0;
      end else if ((state_q == S_DISPATCH) && abort) begin
        aborted_q <= 1'b1;
      end
    end
  end

  // Pixel walk and assignment payload: coordinates advance only on a grant,
  // the frame constants are captured once per frame.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      x_q       <= '0;
      y_q       <= '0;
      assign_x  <= '0;
      assign_y  <= '0;
      assign_id <= '0;
      assign_a  <= '0;
      assign_b  <= '0;
    end else begin
      if ((state_q == S_IDLE) && start_frame) begin
        x_q      <= '0;
        y_q      <= '0;
        assign_a <= a_in;
        assign_b <= b_in;
      end else if (grant_vld_p0) begin
        assign_x  <= x_q;
        assign_y  <= y_q;
        assign_id <= grant_id_p0;
        if (x_q == NUM_X_BITS'(X_MAX - 1)) begin
          x_q <= '0;
          y_q <= (y_q == NUM_Y_BITS'(Y_MAX - 1)) ? '0 : y_q + 1'b1;
        end else begin
          x_q <= x_q + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_julia_work_dispatcher.sv
// Bench for julia_work_dispatcher: directed frame scenarios on a 4-worker,
// 4x2 pixel configuration plus a long randomized run against a pixel-index
// reference model.
module tb_julia_work_dispatcher;

  localparam int NW = 4;
  localparam int XB = 10;
  localparam int YB = 10;
  localparam int XM = 4;
  localparam int YM = 2;
  localparam int CB = 22;
  localparam int IB = 2;

  logic                 clk = 1'b0;
  logic                 n_rst = 1'b0;
  logic                 start_frame = 1'b0;
  logic                 abort = 1'b0;
  logic signed [CB-1:0] a_in = '0;
  logic signed [CB-1:0] b_in = '0;
  logic [NW-1:0]        worker_done = '0;
  logic [NW-1:0]        worker_start;
  logic [XB-1:0]        assign_x;
  logic [YB-1:0]        assign_y;
  logic signed [CB-1:0] assign_a;
  logic signed [CB-1:0] assign_b;
  logic [IB-1:0]        assign_id;
  logic                 assign_valid;
  logic [NW-1:0]        busy_mask;
  logic                 frame_busy;
  logic                 frame_done;
  logic                 frame_aborted;

  int checks = 0;
  int errors = 0;

  julia_work_dispatcher #(
    .NUM_WORKERS(NW), .NUM_X_BITS(XB), .NUM_Y_BITS(YB),
    .X_MAX(XM), .Y_MAX(YM), .C_BITS(CB), .ID_BITS(IB)
  ) dut (
    .clk(clk), .n_rst(n_rst), .start_frame(start_frame), .abort(abort),
    .a_in(a_in), .b_in(b_in), .worker_done(worker_done),
    .worker_start(worker_start), .assign_x(assign_x), .assign_y(assign_y),
    .assign_a(assign_a), .assign_b(assign_b), .assign_id(assign_id),
    .assign_valid(assign_valid), .busy_mask(busy_mask), .frame_busy(frame_busy),
    .frame_done(frame_done), .frame_aborted(frame_aborted)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    start_frame = 1'b0;
    abort       = 1'b0;
    worker_done = '0;
    n_rst       = 1'b0;
    tick();
    tick();
    n_rst = 1'b1;
  endtask

  // Asynchronous reset mid-frame: outputs clear without a clock, no frame_done.
  task automatic test_reset();
    do_reset();
    a_in = 22'sd123;
    b_in = -22'sd9;
    start_frame = 1'b1;
    tick();
    start_frame = 1'b0;
    tick();
    tick();
    #2;
    n_rst = 1'b0;
    #1;
    checks++;
    if ({worker_start, assign_valid, busy_mask, frame_busy, frame_done, frame_aborted} !== '0) begin
      errors++;
      $display("FAIL reset_ctrl got start=%b vld=%b busy=%b fb=%b fd=%b fa=%b want all 0",
               worker_start, assign_valid, busy_mask, frame_busy, frame_done, frame_aborted);
    end
    checks++;
    if ({assign_x, assign_y, assign_id, assign_a, assign_b} !== '0) begin
      errors++;
      $display("FAIL reset_data got x=%0d y=%0d id=%0d a=%0d b=%0d want all 0",
               assign_x, assign_y, assign_id, assign_a, assign_b);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (frame_done !== 1'b0) begin
        errors++;
        $display("FAIL reset_no_done got %b want 0", frame_done);
      end
    end
    n_rst = 1'b1;
    start_frame = 1'b1;
    tick();
    start_frame = 1'b0;
    tick();
    checks++;
    if (worker_start !== 4'b0001 || assign_x !== 10'd0) begin
      errors++;
      $display("FAIL reset_first_grant got start=%b x=%0d want 0001 x=0", worker_start, assign_x);
    end
  endtask

  // Four grants in round-robin order after start, then all workers busy.
  task automatic test_dispatch();
    logic [NW-1:0] e;
    do_reset();
    a_in = 22'sd100;
    b_in = -22'sd100;
    start_frame = 1'b1;
    tick();
    start_frame = 1'b0;
    checks++;
    if (frame_busy !== 1'b1) begin
      errors++;
      $display("FAIL dispatch_frame_busy got %b want 1", frame_busy);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      e = 4'b0001 << i;
      checks++;
      if (worker_start !== e || assign_valid !== 1'b1 || assign_id !== IB'(i)
          || assign_x !== XB'(i) || assign_y !== 10'd0) begin
        errors++;
        $display("FAIL dispatch_grant%0d got start=%b vld=%b id=%0d x=%0d y=%0d want start=%b vld=1 id=%0d x=%0d y=0",
                 i, worker_start, assign_valid, assign_id, assign_x, assign_y, e, i, i);
      end
    end
    tick();
    checks++;
    if (worker_start !== 4'b0000 || assign_valid !== 1'b0 || frame_busy !== 1'b1 || busy_mask !== 4'b1111) begin
      errors++;
      $display("FAIL dispatch_full got start=%b vld=%b fb=%b busy=%b want 0000 0 1 1111",
               worker_start, assign_valid, frame_busy, busy_mask);
    end
    checks++;
    if (assign_x !== 10'd3 || assign_id !== 2'd3) begin
      errors++;
      $display("FAIL dispatch_hold got x=%0d id=%0d want x=3 id=3", assign_x, assign_id);
    end
  endtask

  // One done frees a worker; it is regranted on the following edge.
  task automatic test_done_release();
    worker_done = 4'b0100;
    tick();
    worker_done = '0;
    checks++;
    if (busy_mask !== 4'b1011 || worker_start !== 4'b0000) begin
      errors++;
      $display("FAIL release_busy got busy=%b start=%b want 1011 0000", busy_mask, worker_start);
    end
    tick();
    checks++;
    if (worker_start !== 4'b0100 || assign_id !== 2'd2 || assign_x !== 10'd0 || assign_y !== 10'd1) begin
      errors++;
      $display("FAIL release_grant got start=%b id=%0d x=%0d y=%0d want 0100 2 0 1",
               worker_start, assign_id, assign_x, assign_y);
    end
  endtask

  // Two dones together: pointer at 2 means worker 3 first, then wrap to 0.
  task automatic test_multi_done();
    worker_done = 4'b1001;
    tick();
    worker_done = '0;
    checks++;
    if (busy_mask !== 4'b0110) begin
      errors++;
      $display("FAIL multi_busy got %b want 0110", busy_mask);
    end
    tick();
    checks++;
    if (worker_start !== 4'b1000 || assign_id !== 2'd3 || assign_x !== 10'd1 || assign_y !== 10'd1) begin
      errors++;
      $display("FAIL multi_first got start=%b id=%0d x=%0d y=%0d want 1000 3 1 1",
               worker_start, assign_id, assign_x, assign_y);
    end
    tick();
    checks++;
    if (worker_start !== 4'b0001 || assign_id !== 2'd0 || assign_x !== 10'd2 || assign_y !== 10'd1) begin
      errors++;
      $display("FAIL multi_second got start=%b id=%0d x=%0d y=%0d want 0001 0 2 1",
               worker_start, assign_id, assign_x, assign_y);
    end
  endtask

  // Last pixel, drain, single-cycle frame_done, return to idle.
  task automatic test_frame_complete();
    worker_done = 4'b0010;
    tick();
    worker_done = '0;
    tick();
    checks++;
    if (worker_start !== 4'b0010 || assign_x !== 10'd3 || assign_y !== 10'd1) begin
      errors++;
      $display("FAIL complete_last got start=%b x=%0d y=%0d want 0010 3 1", worker_start, assign_x, assign_y);
    end
    tick();
    tick();
    checks++;
    if (worker_start !== 4'b0000 || frame_busy !== 1'b1 || frame_done !== 1'b0) begin
      errors++;
      $display("FAIL complete_drain got start=%b fb=%b fd=%b want 0000 1 0", worker_start, frame_busy, frame_done);
    end
    worker_done = 4'b1111;
    tick();
    worker_done = '0;
    checks++;
    if (busy_mask !== 4'b0000 || frame_done !== 1'b0) begin
      errors++;
      $display("FAIL complete_empty got busy=%b fd=%b want 0000 0", busy_mask, frame_done);
    end
    tick();
    checks++;
    if (frame_done !== 1'b1 || frame_aborted !== 1'b0 || frame_busy !== 1'b0) begin
      errors++;
      $display("FAIL complete_done got fd=%b fa=%b fb=%b want 1 0 0", frame_done, frame_aborted, frame_busy);
    end
    tick();
    checks++;
    if (frame_done !== 1'b0 || worker_start !== 4'b0000 || frame_busy !== 1'b0) begin
      errors++;
      $display("FAIL complete_idle got fd=%b start=%b fb=%b want 0 0000 0", frame_done, worker_start, frame_busy);
    end
  endtask

  // Abort coinciding with the second grant; aborted done; restart on worker 2.
  task automatic test_abort();
    do_reset();
    start_frame = 1'b1;
    tick();
    start_frame = 1'b0;
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++;
    if (worker_start !== 4'b0010) begin
      errors++;
      $display("FAIL abort_coincident got start=%b want 0010", worker_start);
    end
    tick();
    tick();
    checks++;
    if (worker_start !== 4'b0000 || busy_mask !== 4'b0011 || frame_busy !== 1'b1 || frame_done !== 1'b0) begin
      errors++;
      $display("FAIL abort_stopped got start=%b busy=%b fb=%b fd=%b want 0000 0011 1 0",
               worker_start, busy_mask, frame_busy, frame_done);
    end
    worker_done = 4'b0011;
    tick();
    worker_done = '0;
    tick();
    checks++;
    if (frame_done !== 1'b1 || frame_aborted !== 1'b1) begin
      errors++;
      $display("FAIL abort_done got fd=%b fa=%b want 1 1", frame_done, frame_aborted);
    end
    tick();
    start_frame = 1'b1;
    tick();
    start_frame = 1'b0;
    tick();
    checks++;
    if (worker_start !== 4'b0100 || assign_id !== 2'd2 || assign_x !== 10'd0 || assign_y !== 10'd0) begin
      errors++;
      $display("FAIL abort_restart got start=%b id=%0d x=%0d y=%0d want 0100 2 0 0",
               worker_start, assign_id, assign_x, assign_y);
    end
  endtask

  // Constants latched once; mid-frame input changes and start_frame ignored.
  task automatic test_constants();
    do_reset();
    a_in = 22'sh0ABCD;
    b_in = -22'sd5;
    start_frame = 1'b1;
    tick();
    a_in = 22'sh12345;
    b_in = 22'sd77;
    tick();
    start_frame = 1'b0;
    checks++;
    if (assign_a !== 22'sh0ABCD || assign_b !== -22'sd5 || worker_start !== 4'b0001) begin
      errors++;
      $display("FAIL const_first got a=%h b=%0d start=%b want 0abcd -5 0001", assign_a, assign_b, worker_start);
    end
    tick();
    checks++;
    if (assign_a !== 22'sh0ABCD || assign_b !== -22'sd5 || worker_start !== 4'b0010 || assign_x !== 10'd1) begin
      errors++;
      $display("FAIL const_second got a=%h b=%0d start=%b x=%0d want 0abcd -5 0010 1",
               assign_a, assign_b, worker_start, assign_x);
    end
  endtask

  // Randomized run against a model built on a pixel index and a busy table.
  task automatic test_random();
    int phase, ptr, pix, g, cand;
    bit mb[NW];
    bit nb[NW];
    bit m_ab;
    int m_x, m_y, m_id;
    logic signed [CB-1:0] m_a, m_b;
    logic [NW-1:0] exp_start, exp_busy;
    logic exp_valid, exp_fd, exp_fa, exp_fb, any_busy;
    logic [NW-1:0] dn;
    logic sf, ab;
    do_reset();
    phase = 0; ptr = NW - 1; pix = 0; m_ab = 1'b0;
    m_x = 0; m_y = 0; m_id = 0; m_a = '0; m_b = '0;
    for (int i = 0; i < NW; i++) mb[i] = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      sf = ($urandom_range(3) == 0);
      ab = ($urandom_range(15) == 0);
      dn = NW'($urandom & $urandom);
      start_frame = sf;
      abort       = ab;
      worker_done = dn;
      a_in        = CB'($urandom);
      b_in        = CB'($urandom);
      exp_start = '0; exp_valid = 1'b0; exp_fd = 1'b0; exp_fa = 1'b0;
      any_busy = 1'b0;
      for (int i = 0; i < NW; i++) begin
        nb[i] = mb[i] && !dn[i];
        if (mb[i]) any_busy = 1'b1;
      end
      case (phase)
        0: if (sf) begin
          m_a = a_in; m_b = b_in; pix = 0; m_ab = 1'b0; phase = 1;
        end
        1: begin
          g = -1;
          cand = 1;
          while (cand <= NW && g < 0) begin
            if (!mb[(ptr + cand) % NW]) g = (ptr + cand) % NW;
            cand++;
          end
          if (g >= 0) begin
            exp_start[g] = 1'b1; exp_valid = 1'b1;
            m_id = g; m_x = pix % XM; m_y = pix / XM;
            nb[g] = 1'b1; ptr = g; pix++;
          end
          if (ab) m_ab = 1'b1;
          if (ab || pix == XM * YM) phase = 2;
        end
        2: if (!any_busy) begin
          phase = 3; exp_fd = 1'b1; exp_fa = m_ab;
        end
        default: phase = 0;
      endcase
      for (int i = 0; i < NW; i++) begin
        mb[i] = nb[i];
        exp_busy[i] = nb[i];
      end
      exp_fb = (phase == 1) || (phase == 2);
      tick();
      checks++;
      if (worker_start !== exp_start || assign_valid !== exp_valid) begin
        errors++;
        $display("FAIL rand_start cyc=%0d got start=%b vld=%b want %b %b", cyc, worker_start, assign_valid, exp_start, exp_valid);
      end
      checks++;
      if (busy_mask !== exp_busy || frame_busy !== exp_fb) begin
        errors++;
        $display("FAIL rand_busy cyc=%0d got busy=%b fb=%b want %b %b", cyc, busy_mask, frame_busy, exp_busy, exp_fb);
      end
      checks++;
      if (frame_done !== exp_fd || frame_aborted !== exp_fa) begin
        errors++;
        $display("FAIL rand_done cyc=%0d got fd=%b fa=%b want %b %b", cyc, frame_done, frame_aborted, exp_fd, exp_fa);
      end
      checks++;
      if (assign_x !== XB'(m_x) || assign_y !== YB'(m_y) || assign_id !== IB'(m_id)) begin
        errors++;
        $display("FAIL rand_coord cyc=%0d got x=%0d y=%0d id=%0d want %0d %0d %0d",
                 cyc, assign_x, assign_y, assign_id, m_x, m_y, m_id);
      end
      checks++;
      if (assign_a !== m_a || assign_b !== m_b) begin
        errors++;
        $display("FAIL rand_const cyc=%0d got a=%0d b=%0d want %0d %0d", cyc, assign_a, assign_b, m_a, m_b);
      end
    end
    start_frame = 1'b0;
    abort = 1'b0;
    worker_done = '0;
  endtask

  initial begin
    test_reset();
    test_dispatch();
    test_done_release();
    test_multi_done();
    test_frame_complete();
    test_abort();
    test_constants();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
